padbid_halfduplex_ctrl: RTL and testbench

- Core-side controller for one PADBID bidirectional pad. It drives the pad's I and OEN pins and samples the pad's C pin.
- Runs a half-duplex serial exchange over one wire. Each exchange sends one framed command word, turns the line around, then receives one framed response word from the far-end responder.
- Sits between a simple valid/ready core interface and a PADBID instance on a shared inout net.
- The net has an external pull-up, so the released line reads 1.

---
 rtl/padbid_halfduplex_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_padbid_halfduplex_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/padbid_halfduplex_ctrl.sv
// Core-side half-duplex controller for a single PADBID bidirectional pad.
// One exchange: framed command out (start 0, WIDTH data bits LSB first,
// stop 1), line turnaround, then a framed response back from the far end.
// Every output is registered from the next state, so pad_oen/pad_i change
// only on the clock edge and the first frame bit appears right after the
// accept edge. With a zero-delay responder, rx_valid is high in the cycle
// that follows edge (WIDTH+2)+TURN_CYCLES+1+WIDTH+1 after the accept edge.
module padbid_halfduplex_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_err_timeout,
  output logic             rx_err_stop,
  output logic             busy,
  output logic             pad_i,
  output logic             pad_oen,
  input  logic             pad_c
);

  localparam int              BCW       = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0]  BIT_LAST  = BCW'(WIDTH - 1);
  localparam logic [7:0]      TURN_LAST = 8'(TURN_CYCLES - 1);
  localparam logic [7:0]      TMO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_TX_START = 4'd1,
    S_TX_DATA  = 4'd2,
    S_TX_STOP  = 4'd3,
    S_TURN     = 4'd4,
    S_WAIT     = 4'd5,
    S_RX_DATA  = 4'd6,
    S_RX_STOP  = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BCW-1:0]   r_bit_cnt;
  logic [7:0]       r_tmo_cnt;
  logic [WIDTH-1:0] r_tx_sh;
  logic [WIDTH-1:0] r_rx_sh;
  logic [WIDTH:0]   w_rx_cat;
  logic             w_tmo_hit;
  logic             w_stop_bad;
  logic             w_pad_oen_nxt;
  logic             w_pad_i_nxt;

  // The new line bit enters at the MSB; after WIDTH shifts the first bit is the LSB.
  assign w_rx_cat = {pad_c, r_rx_sh};

  // Next-state logic plus the two error conditions that are latched when entering DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_hit   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          w_state_nxt = S_TX_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TX_START: w_state_nxt = S_TX_DATA;
      S_TX_DATA: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_state_nxt = S_TX_STOP;
        end else begin
          w_state_nxt = S_TX_DATA;
        end
      end
      S_TX_STOP: w_state_nxt = S_TURN;
      S_TURN: begin
        if (r_tmo_cnt == TURN_LAST) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_TURN;
        end
      end
      S_WAIT: begin
        // A start bit on the final search cycle still wins over the timeout.
        if (!pad_c) begin
          w_state_nxt = S_RX_DATA;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nxt = S_DONE;
          w_tmo_hit   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RX_DATA: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_state_nxt = S_RX_STOP;
        end else begin
          w_state_nxt = S_RX_DATA;
        end
      end
      S_RX_STOP: begin
        w_state_nxt = S_DONE;
        w_stop_bad  = ~pad_c;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pad drive for the upcoming state; only the TX frame states enable the driver.
  always_comb begin
    w_pad_oen_nxt = 1'b1;
    w_pad_i_nxt   = 1'b1;
    case (w_state_nxt)
      S_TX_START: begin
        w_pad_oen_nxt = 1'b0;
        w_pad_i_nxt   = 1'b0;
      end
      S_TX_DATA: begin
        w_pad_oen_nxt = 1'b0;
        w_pad_i_nxt   = r_tx_sh[0];
      end
      S_TX_STOP: begin
        w_pad_oen_nxt = 1'b0;
        w_pad_i_nxt   = 1'b1;
      end
      default: begin
        w_pad_oen_nxt = 1'b1;
        w_pad_i_nxt   = 1'b1;
      end
    endcase
  end

  // State register and registered outputs, all derived from the next state.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state        <= S_IDLE;
      tx_ready       <= 1'b1;
      busy           <= 1'b0;
      pad_oen        <= 1'b1;
      pad_i          <= 1'b1;
      rx_valid       <= 1'b0;
      rx_err_timeout <= 1'b0;
      rx_err_stop    <= 1'b0;
      rx_data        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      tx_ready       <= (w_state_nxt == S_IDLE);
      busy           <= (w_state_nxt != S_IDLE);
      pad_oen        <= w_pad_oen_nxt;
      pad_i          <= w_pad_i_nxt;
      rx_valid       <= (w_state_nxt == S_DONE);
      rx_err_timeout <= w_tmo_hit;
      rx_err_stop    <= w_stop_bad;
      // A received frame (good or bad stop) replaces rx_data; a timeout keeps the old word.
      if (r_state == S_RX_STOP) begin
        rx_data <= r_rx_sh;
      end else begin
        rx_data <= rx_data;
      end
    end
  end

  // Bit and cycle counters: cleared on every state entry, advanced only where they are used.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_bit_cnt <= '0;
      r_tmo_cnt <= 8'd0;
    end else if (w_state_nxt != r_state) begin
      r_bit_cnt <= '0;
      r_tmo_cnt <= 8'd0;
    end else begin
      if ((r_state == S_TX_DATA) || (r_state == S_RX_DATA)) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
      if ((r_state == S_TURN) || (r_state == S_WAIT)) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt;
      end
    end
  end

  // TX word is loaded on accept and shifted out one bit per TX_DATA cycle; RX bits shift in.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_tx_sh <= '0;
      r_rx_sh <= '0;
    end else begin
      if ((r_state == S_IDLE) && (w_state_nxt == S_TX_START)) begin
        r_tx_sh <= tx_data;
      end else if (w_state_nxt == S_TX_DATA) begin
        r_tx_sh <= r_tx_sh >> 1'b1;
      end else begin
        r_tx_sh <= r_tx_sh;
      end
      if (r_state == S_RX_DATA) begin
        r_rx_sh <= w_rx_cat[WIDTH:1];
      end else begin
        r_rx_sh <= r_rx_sh;
      end
    end
  end

endmodule

// File: tb/tb_padbid_halfduplex_ctrl.sv
// Bench for padbid_halfduplex_ctrl: models the shared pad net with pull-up and a
// far-end responder, and predicts each exchange from frame timing arithmetic.
module tb_padbid_halfduplex_ctrl;

  localparam int W    = 8;
  localparam int TURN = 2;
  localparam int TMO  = 16;

  logic         CK = 1'b0;
  logic         RST = 1'b1;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] tx_data = '0;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         rx_err_timeout;
  logic         rx_err_stop;
  logic         busy;
  logic         pad_i;
  logic         pad_oen;
  logic         pad_c = 1'b1;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_rx = '0;

  padbid_halfduplex_ctrl #(.WIDTH(W), .TURN_CYCLES(TURN), .TIMEOUT(TMO)) dut (
    .CK(CK), .RST(RST), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err_timeout(rx_err_timeout),
    .rx_err_stop(rx_err_stop), .busy(busy), .pad_i(pad_i), .pad_oen(pad_oen),
    .pad_c(pad_c)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_oen"}, 32'(pad_oen), 32'd1);
    chk({tag, "_pad_i"}, 32'(pad_i), 32'd1);
    chk({tag, "_ready"}, 32'(tx_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rxv"}, 32'(rx_valid), 32'd0);
  endtask

  // One exchange. Cycle c counts edges after the accept edge (c=0 is the start bit).
  // Responder start bit sits in WAIT cycle d+1; never=1 means it stays silent.
  task automatic run_exchange(input logic [W-1:0] tx, input int d, input bit never,
                              input logic [W-1:0] rxw, input bit stop_bit,
                              input bit noise, input int abort_at);
    int  c_s;
    int  c_done;
    bit  exp_oen;
    bit  exp_i;
    chk("pre_ready", 32'(tx_ready), 32'd1);
    chk("pre_busy", 32'(busy), 32'd0);
    tx_valid = 1'b1;
    tx_data  = tx;
    tick();
    c_s    = W + 2 + TURN + d;
    c_done = never ? (W + 2 + TURN + TMO) : (c_s + W + 2);
    for (int c = 0; c <= c_done; c++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = W'($urandom);
      // Expected pad drive from the frame layout.
      if (c == 0) begin
        exp_oen = 1'b0; exp_i = 1'b0;
      end else if (c <= W) begin
        exp_oen = 1'b0; exp_i = tx[c-1];
      end else if (c == W + 1) begin
        exp_oen = 1'b0; exp_i = 1'b1;
      end else begin
        exp_oen = 1'b1; exp_i = 1'b1;
      end
      chk("pad_oen", 32'(pad_oen), 32'(exp_oen));
      if (c <= W + 1 + TURN) chk("pad_i", 32'(pad_i), 32'(exp_i));
      chk("busy", 32'(busy), 32'd1);
      chk("tx_ready", 32'(tx_ready), 32'd0);
      chk("rx_valid", 32'(rx_valid), 32'(c == c_done));
      if (c == c_done) begin
        if (!never) exp_rx = rxw;
        chk("rx_data", 32'(rx_data), 32'(exp_rx));
        chk("err_timeout", 32'(rx_err_timeout), 32'(never));
        chk("err_stop", 32'(rx_err_stop), 32'(!never && !stop_bit));
        tx_valid = 1'b0;
      end else begin
        chk("err_quiet", 32'({rx_err_timeout, rx_err_stop}), 32'd0);
      end
      if (c == abort_at) begin
        RST      = 1'b1;
        tx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk_idle("rst");
          chk("rst_rx_data", 32'(rx_data), 32'd0);
        end
        RST      = 1'b0;
        tx_valid = 1'b0;
        exp_rx   = '0;
        pad_c    = 1'b1;
        tick();
        chk_idle("post_rst");
        return;
      end
      // Net level: our driver when enabled, otherwise responder or pull-up.
      if (!pad_oen) begin
        pad_c = pad_i;
      end else if (noise && (c >= W + 2) && (c <= W + 1 + TURN)) begin
        pad_c = 1'($urandom_range(0, 1));
      end else if (!never && (c == c_s)) begin
        pad_c = 1'b0;
      end else if (!never && (c > c_s) && (c <= c_s + W)) begin
        pad_c = rxw[c-c_s-1];
      end else if (!never && (c == c_s + W + 1)) begin
        pad_c = stop_bit;
      end else begin
        pad_c = 1'b1;
      end
      tick();
    end
    pad_c = 1'b1;
    chk_idle("after_done");
  endtask

  initial begin
    tick(); tick(); tick();
    chk_idle("reset");
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_errs", 32'({rx_err_timeout, rx_err_stop}), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("idle");
    end
    // Directed: nominal, timeout, stop error, late start bit at the search limit.
    run_exchange(8'hA5, 0, 1'b0, 8'h3C, 1'b1, 1'b0, -1);
    run_exchange(8'h11, 0, 1'b1, 8'h00, 1'b1, 1'b0, -1);
    run_exchange(8'h7E, 0, 1'b0, 8'hFF, 1'b0, 1'b0, -1);
    run_exchange(8'hC3, TMO - 1, 1'b0, 8'h5A, 1'b1, 1'b1, -1);
    // Reset during TX_DATA bit 3, then a clean exchange.
    run_exchange(8'h96, 0, 1'b0, 8'h12, 1'b1, 1'b0, 4);
    run_exchange(8'h2B, 3, 1'b0, 8'hE1, 1'b1, 1'b1, -1);
    // Randomized exchanges, back to back.
    for (int n = 0; n < 24; n++) begin
      run_exchange(W'($urandom), int'($urandom_range(0, TMO - 1)),
                   ($urandom_range(0, 7) == 0), W'($urandom),
                   ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
